// File: rtl/msk_frame_sync.sv
// msk_frame_sync: frame synchroniser for the MSK demodulator's hard-decision bit stream.
// Hunts for a sync word with up to MAX_ERR bit errors, optionally in either polarity,
// then reads an 8-bit length field and emits that many payload bytes with frame markers.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   bit_in     demodulated bit, qualified by bit_val
//   bit_val    one-cycle strobe for bit_in
//   byte_out   payload byte, MSB = first received bit; holds between pulses
//   byte_val   one-cycle pulse, byte_out valid
//   sof / eof  first / last payload byte markers, coincident with byte_val
//   sync_det   one-cycle pulse on sync acceptance
//   inverted   polarity of the current/last frame (1 = inverted sync matched)
//   frame_cnt  number of accepted syncs with nonzero length, wrapping

module msk_frame_sync #(
  parameter int unsigned SYNC_LEN  = 32,
  parameter logic [63:0] SYNC_WORD = 64'h1ACFFC1D,
  parameter int unsigned MAX_ERR   = 2,
  parameter bit          INV_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_in,
  input  logic        bit_val,
  output logic [7:0]  byte_out,
  output logic        byte_val,
  output logic        sof,
  output logic        eof,
  output logic        sync_det,
  output logic        inverted,
  output logic [15:0] frame_cnt
);

  localparam logic [SYNC_LEN-1:0] SyncW    = SYNC_WORD[SYNC_LEN-1:0];
  localparam logic [6:0]          SyncLenC = 7'(SYNC_LEN);
  localparam logic [6:0]          MaxErrC  = 7'(MAX_ERR);

  typedef enum logic [1:0] {StHunt, StLen, StPay} state_e;

  state_e              state_q;
  logic [SYNC_LEN-1:0] sr_q;
  logic [6:0]          hunt_cnt_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          shift_q;
  logic [7:0]          byte_cnt_q;
  logic                first_q;
  logic [7:0]          byte_out_q;
  logic                byte_val_q;
  logic                sof_q;
  logic                eof_q;
  logic                sync_det_q;
  logic                inverted_q;
  logic [15:0]         frame_cnt_q;

  logic [SYNC_LEN-1:0] sr_next;
  logic [6:0]          hunt_inc;
  logic [6:0]          dist_norm;
  logic [6:0]          dist_inv;
  logic                match_norm;
  logic                match_inv;
  logic [7:0]          shift_next;
  logic                last_bit;

  function automatic logic [6:0] popcnt(input logic [SYNC_LEN-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  always_comb begin
    sr_next    = {sr_q[SYNC_LEN-2:0], bit_in};
    // Saturating at SYNC_LEN makes "== SyncLenC" equivalent to ">= SYNC_LEN".
    hunt_inc   = (hunt_cnt_q == SyncLenC) ? hunt_cnt_q : hunt_cnt_q + 7'd1;
    dist_norm  = popcnt(sr_next ^ SyncW);
    dist_inv   = popcnt(sr_next ^ ~SyncW);
    match_norm = (hunt_inc == SyncLenC) && (dist_norm <= MaxErrC);
    match_inv  = INV_EN && (hunt_inc == SyncLenC) && (dist_inv <= MaxErrC);
    // Length and payload bits are de-inverted with the polarity latched at sync.
    shift_next = {shift_q[6:0], bit_in ^ inverted_q};
    last_bit   = (bit_cnt_q == 3'd7);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHunt;
      sr_q        <= '0;
      hunt_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      first_q     <= 1'b0;
      byte_out_q  <= '0;
      byte_val_q  <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      sync_det_q  <= 1'b0;
      inverted_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      byte_val_q <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      sync_det_q <= 1'b0;
      if (bit_val) begin
        unique case (state_q)
          StHunt: begin
            sr_q       <= sr_next;
            hunt_cnt_q <= hunt_inc;
            // Normal polarity takes priority when both distances qualify.
            if (match_norm) begin
              inverted_q <= 1'b0;
              sync_det_q <= 1'b1;
              bit_cnt_q  <= '0;
              hunt_cnt_q <= '0;
              state_q    <= StLen;
            end else if (match_inv) begin
              inverted_q <= 1'b1;
              sync_det_q <= 1'b1;
              bit_cnt_q  <= '0;
              hunt_cnt_q <= '0;
              state_q    <= StLen;
            end
          end
          StLen: begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (shift_next == 8'd0) begin
                hunt_cnt_q <= '0;
                state_q    <= StHunt;
              end else begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                byte_cnt_q  <= shift_next;
                first_q     <= 1'b1;
                state_q     <= StPay;
              end
            end
          end
          StPay: begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              byte_out_q <= shift_next;
              byte_val_q <= 1'b1;
              sof_q      <= first_q;
              eof_q      <= (byte_cnt_q == 8'd1);
              first_q    <= 1'b0;
              byte_cnt_q <= byte_cnt_q - 8'd1;
              if (byte_cnt_q == 8'd1) begin
                hunt_cnt_q <= '0;
                state_q    <= StHunt;
              end
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign byte_out  = byte_out_q;
  assign byte_val  = byte_val_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign sync_det  = sync_det_q;
  assign inverted  = inverted_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_msk_frame_sync.sv
// Directed bench for msk_frame_sync: table of frame vectors plus a mid-frame reset sequence.

module tb_msk_frame_sync;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_val = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_val;
  logic        sof;
  logic        eof;
  logic        sync_det;
  logic        inverted;
  logic [15:0] frame_cnt;

  msk_frame_sync dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bit_in   (bit_in),
    .bit_val  (bit_val),
    .byte_out (byte_out),
    .byte_val (byte_val),
    .sof      (sof),
    .eof      (eof),
    .sync_det (sync_det),
    .inverted (inverted),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sync;       // sync word as sent on the wire
    logic        inv_wire;   // invert length and payload on the wire
    logic [7:0]  len;        // length field (before wire inversion)
    logic [31:0] pay;        // up to 4 payload bytes, first byte in [31:24]
    int unsigned gap_max;    // max idle cycles before each bit
    logic        exp_sync;
    logic        exp_inv;
    int unsigned exp_nbytes;
    logic [15:0] exp_fc;
  } vec_t;

  vec_t vecs[8];

  int n_vec = 0;
  int n_miss = 0;

  // Output monitor, sampled on the falling edge.
  int         sync_seen = 0;
  logic [9:0] bq[$];
  always @(negedge clk) begin
    if (sync_det) sync_seen++;
    if (byte_val) bq.push_back({sof, eof, byte_out});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    bit_val = 1'b0;
    repeat (n) begin
      bit_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int unsigned gap_max);
    int unsigned g;
    g = (gap_max != 0) ? $urandom_range(0, gap_max) : 0;
    idle(g);
    bit_in  = b;
    bit_val = 1'b1;
    @(posedge clk);
    #1;
    bit_val = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
    for (int i = 7; i >= 0; i--) send_bit(b[i], gap_max);
  endtask

  task automatic apply(input vec_t v, input int idx);
    int          s0;
    int          b0;
    int unsigned nb;
    logic [9:0]  e;
    logic [7:0]  wl;
    logic [7:0]  pb;
    string       tag;
    s0 = sync_seen;
    b0 = bq.size();
    for (int i = 31; i >= 0; i--) send_bit(v.sync[i], v.gap_max);
    tag = $sformatf("v%0d", idx);
    chk({tag, " sync_det after bit 32"}, 32'(sync_det), 32'(v.exp_sync));
    wl = v.len ^ {8{v.inv_wire}};
    send_byte(wl, v.gap_max);
    for (int k = 0; k < int'(v.len); k++) begin
      pb = v.pay[31-8*k -: 8];
      send_byte(pb ^ {8{v.inv_wire}}, v.gap_max);
    end
    idle(4);
    chk({tag, " sync_det pulses"}, 32'(sync_seen - s0), 32'(v.exp_sync));
    nb = bq.size() - b0;
    chk({tag, " byte count"}, nb, v.exp_nbytes);
    for (int k = 0; k < int'(v.exp_nbytes); k++) begin
      if (b0 + k < bq.size()) begin
        pb = v.pay[31-8*k -: 8];
        e  = {k == 0, k == int'(v.exp_nbytes) - 1, pb};
        chk($sformatf("%s byte%0d {sof,eof,byte}", tag, k), 32'(bq[b0+k]), 32'(e));
      end
    end
    chk({tag, " inverted"}, 32'(inverted), 32'(v.exp_inv));
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(v.exp_fc));
    if (v.exp_nbytes != 0) begin
      pb = v.pay[31-8*(v.exp_nbytes-1) -: 8];
      chk({tag, " byte_out hold"}, 32'(byte_out), 32'(pb));
    end
  endtask

  initial begin
    vec_t clean;
    //               sync          inv   len    payload        gap sync  inv  nb  fc
    vecs[0] = '{32'h1ACFFC1D, 1'b0, 8'h03, 32'hA53C7E00,  0, 1'b1, 1'b0, 3, 16'd1};
    vecs[1] = '{32'hE53003E2, 1'b1, 8'h03, 32'hA53C7E00,  0, 1'b1, 1'b1, 3, 16'd2};
    vecs[2] = '{32'h9ACFFC1C, 1'b0, 8'h01, 32'h42000000,  0, 1'b1, 1'b0, 1, 16'd3};
    vecs[3] = '{32'hE53102E2, 1'b1, 8'h02, 32'h0FF00000,  0, 1'b1, 1'b1, 2, 16'd4};
    vecs[4] = '{32'h1ACFFC1A, 1'b0, 8'h00, 32'h00000000,  0, 1'b0, 1'b1, 0, 16'd4};
    vecs[5] = '{32'h1ACFFC1D, 1'b0, 8'h00, 32'h00000000,  0, 1'b1, 1'b0, 0, 16'd4};
    vecs[6] = '{32'h1ACFFC1D, 1'b0, 8'h01, 32'h55000000,  0, 1'b1, 1'b0, 1, 16'd5};
    vecs[7] = '{32'h1ACFFC1D, 1'b0, 8'h04, 32'h1ACFFC1D, 38, 1'b1, 1'b0, 4, 16'd6};
    clean   = '{32'h1ACFFC1D, 1'b0, 8'h02, 32'hC3960000,  3, 1'b1, 1'b0, 2, 16'd1};

    // Reset state.
    #12;
    chk("reset byte_out", 32'(byte_out), 32'h0);
    chk("reset flags {byte_val,sof,eof,sync_det,inverted}",
        32'({byte_val, sof, eof, sync_det, inverted}), 32'h0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(3);

    for (int i = 0; i < 8; i++) apply(vecs[i], i);

    // Mid-frame reset: inverted frame, 12 payload bits in, then reset.
    for (int i = 31; i >= 0; i--) send_bit(vecs[1].sync[i], 0);
    send_byte(8'hFC, 0);              // len 0x03 inverted
    send_byte(8'h5A, 0);              // 0xA5 inverted
    for (int i = 7; i >= 4; i--) send_bit(~8'h3C >> i, 0);
    chk("pre-reset inverted", 32'(inverted), 32'h1);
    chk("pre-reset frame_cnt", 32'(frame_cnt), 32'd7);
    reset_n = 1'b0;
    #1;
    chk("mid-frame reset byte_out", 32'(byte_out), 32'h0);
    chk("mid-frame reset flags {byte_val,sof,eof,sync_det,inverted}",
        32'({byte_val, sof, eof, sync_det, inverted}), 32'h0);
    chk("mid-frame reset frame_cnt", 32'(frame_cnt), 32'h0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    apply(clean, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
